// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues one outstanding imem request at a time,
// buffers a returned word and loads the IF/ID register consumed by decode.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ifu_update,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        ifu_stall,
    output logic [31:0] ifu_instr,
    output logic [63:0] ifu_pc,
    output logic [63:0] ifu_snxt_pc,
    output logic        ifu_valid
);

    localparam logic [63:0] Step = 64'(PC_STEP);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] snxt_q, snxt_d;
    logic        valid_q, valid_d;
    // Set by reset until the first new handshake: a response from an abandoned pre-reset
    // transaction may still arrive and is legal to ignore.
    logic        stale_ok_q, stale_ok_d;

    logic        req_fire;
    logic        resp_ok;
    logic        have_instr;
    logic        load;
    logic [31:0] instr_src;

    always_comb begin
        req_fire   = (state_q == StReq) && imem_req_ready;
        resp_ok    = (state_q == StWait) && imem_resp_valid && !drop_q;
        have_instr = resp_ok || (state_q == StHold);
        instr_src  = (state_q == StHold) ? buf_q : imem_resp_data;
        load       = ifu_update && have_instr && !redirect_en;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        buf_d      = buf_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        snxt_d     = snxt_q;
        valid_d    = valid_q;
        stale_ok_d = stale_ok_q && !req_fire;

        if (ifu_update) begin
            valid_d = load;
            instr_d = load ? instr_src : 32'h0;
            pc_d    = load ? fetch_pc_q : 64'h0;
            snxt_d  = load ? fetch_pc_q + Step : 64'h0;
        end

        if (redirect_en) begin
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            case (state_q)
                StReq: begin
                    if (imem_req_ready) begin
                        state_d = StWait;
                        drop_d  = 1'b1;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StReq: begin
                    if (imem_req_ready) state_d = StWait;
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = StReq;
                        end else if (ifu_update) begin
                            fetch_pc_d = fetch_pc_q + Step;
                            state_d    = StReq;
                        end else begin
                            buf_d   = imem_resp_data;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (ifu_update) begin
                        fetch_pc_d = fetch_pc_q + Step;
                        state_d    = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            buf_q      <= 32'h0;
            instr_q    <= 32'h0;
            pc_q       <= 64'h0;
            snxt_q     <= 64'h0;
            valid_q    <= 1'b0;
            stale_ok_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            snxt_q     <= snxt_d;
            valid_q    <= valid_d;
            stale_ok_q <= stale_ok_d;
        end
    end

    always_comb begin
        imem_req_valid = rstn && (state_q == StReq);
        imem_req_addr  = fetch_pc_q;
        ifu_stall      = !have_instr;
        ifu_instr      = instr_q;
        ifu_pc         = pc_q;
        ifu_snxt_pc    = snxt_q;
        ifu_valid      = valid_q;
    end

    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rstn)
        imem_resp_valid |-> (state_q == StWait) || stale_ok_q)
        else $error("imem response outside WAIT");

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: zero-wait fetch, HOLD, redirects, stalled memory, PC wrap, reset.
module tb_ifu_fetch;

    localparam logic [63:0] RstPc = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rstn;
    logic        ifu_update;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifu_stall;
    logic [31:0] ifu_instr;
    logic [63:0] ifu_pc;
    logic [63:0] ifu_snxt_pc;
    logic        ifu_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rstn           (rstn),
        .ifu_update     (ifu_update),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .ifu_stall      (ifu_stall),
        .ifu_instr      (ifu_instr),
        .ifu_pc         (ifu_pc),
        .ifu_snxt_pc    (ifu_snxt_pc),
        .ifu_valid      (ifu_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; ifu_update = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // Reset state and zero-wait streaming
        @(negedge clk); @(negedge clk);
        #1;
        check_eq("rst_valid", ifu_valid, 0);
        check_eq("rst_instr", ifu_instr, 0);
        check_eq("rst_pc", ifu_pc, 0);
        check_eq("rst_snxt", ifu_snxt_pc, 0);
        check_eq("rst_reqv", imem_req_valid, 0);
        rstn = 1'b1;
        #1;
        check_eq("t1_reqv0", imem_req_valid, 1);
        check_eq("t1_addr0", imem_req_addr, RstPc);
        check_eq("t1_stall0", ifu_stall, 1);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        #1;
        check_eq("t1_wait_reqv", imem_req_valid, 0);
        check_eq("t1_wait_stall", ifu_stall, 0);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t1_valid", ifu_valid, 1);
        check_eq("t1_pc", ifu_pc, RstPc);
        check_eq("t1_snxt", ifu_snxt_pc, RstPc + 4);
        check_eq("t1_instr", ifu_instr, 32'h13);
        check_eq("t1_addr1", imem_req_addr, RstPc + 4);
        check_eq("t1_reqv1", imem_req_valid, 1);
        @(negedge clk);
        #1;
        check_eq("t1_bub_valid", ifu_valid, 0);
        check_eq("t1_bub_instr", ifu_instr, 0);
        imem_resp_valid = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t1_valid2", ifu_valid, 1);
        check_eq("t1_pc2", ifu_pc, RstPc + 4);
        check_eq("t1_addr2", imem_req_addr, RstPc + 8);

        // HOLD while decode is stalled
        do_reset();
        ifu_update = 1'b0;
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_2222;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t2_hold_stall", ifu_stall, 0);
        check_eq("t2_hold_reqv", imem_req_valid, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("t2_hold_reqv_n", imem_req_valid, 0);
            check_eq("t2_hold_stall_n", ifu_stall, 0);
            check_eq("t2_hold_valid_n", ifu_valid, 0);
        end
        ifu_update = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t2_valid", ifu_valid, 1);
        check_eq("t2_pc", ifu_pc, RstPc);
        check_eq("t2_instr", ifu_instr, 32'h1111_2222);
        check_eq("t2_addr", imem_req_addr, RstPc + 4);
        check_eq("t2_reqv", imem_req_valid, 1);

        // Redirect during a slow WAIT drops the in-flight response
        do_reset();
        @(negedge clk);
        #1;
        check_eq("t3_w1_reqv", imem_req_valid, 0);
        @(negedge clk);
        redirect_en = 1'b1; redirect_pc = 64'h0000_0000_8000_1002;
        @(negedge clk);
        redirect_en = 1'b0;
        #1;
        check_eq("t3_w3_reqv", imem_req_valid, 0);
        check_eq("t3_w3_valid", ifu_valid, 0);
        check_eq("t3_w3_stall", ifu_stall, 1);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_dead;
        #1;
        check_eq("t3_drop_stall", ifu_stall, 1);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t3_reqv", imem_req_valid, 1);
        check_eq("t3_addr", imem_req_addr, 64'h0000_0000_8000_1000);
        check_eq("t3_valid", ifu_valid, 0);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t3_new_valid", ifu_valid, 1);
        check_eq("t3_new_pc", ifu_pc, 64'h0000_0000_8000_1000);
        check_eq("t3_new_instr", ifu_instr, 32'h0010_0093);

        // Redirect coincident with the response
        do_reset();
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0bad;
        redirect_en = 1'b1; redirect_pc = 64'h2000;
        #1;
        check_eq("t4_stall", ifu_stall, 0);
        @(negedge clk);
        imem_resp_valid = 1'b0; redirect_en = 1'b0;
        #1;
        check_eq("t4_addr", imem_req_addr, 64'h2000);
        check_eq("t4_reqv", imem_req_valid, 1);
        check_eq("t4_valid", ifu_valid, 0);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
        @(negedge clk);
        imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
        #1;
        check_eq("t4_new_valid", ifu_valid, 1);
        check_eq("t4_new_pc", ifu_pc, 64'h2000);
        check_eq("t4_new_snxt", ifu_snxt_pc, 64'h2004);
        check_eq("t4_new_instr", ifu_instr, 32'h0020_0113);

        // Memory not ready: address stable, bubbles loaded
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("t5_addr", imem_req_addr, 64'h2004);
            check_eq("t5_reqv", imem_req_valid, 1);
            check_eq("t5_valid", ifu_valid, 0);
            check_eq("t5_instr", ifu_instr, 0);
        end

        // Redirect to the top of the address space, then wrap
        redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        redirect_en = 1'b0; imem_req_ready = 1'b1;
        #1;
        check_eq("t7_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t7_pc", ifu_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("t7_snxt", ifu_snxt_pc, 64'h0);
        check_eq("t7_next_addr", imem_req_addr, 64'h0);

        // Reset while WAIT; late response after release is ignored
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t6_rst_reqv", imem_req_valid, 0);
        rstn = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h0bad_0bad;
        imem_req_ready = 1'b0;
        #1;
        check_eq("t6_reqv", imem_req_valid, 1);
        check_eq("t6_addr", imem_req_addr, RstPc);
        check_eq("t6_stall", ifu_stall, 1);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check_eq("t6_valid", ifu_valid, 0);
        check_eq("t6_instr", ifu_instr, 0);
        check_eq("t6_pc", ifu_pc, 0);
        check_eq("t6_snxt", ifu_snxt_pc, 0);
        check_eq("t6_addr2", imem_req_addr, RstPc);
        check_eq("t6_reqv2", imem_req_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
